rodrigues_sched: RTL and testbench
==================================

Name: rodrigues_sched

Overview:
- Round-robin scheduler that shares one Rodrigues twist-to-pose engine between NUM_REQ requesters (for example, the per-level ICP solvers and the pose-refinement path).
- Accepts a 6-word twist (phi_x, phi_y, phi_z, tx, ty, tz) from the granted requester and issues a one-cycle start to the engine.
- Captures the 12-word pose on the engine's done pulse, then returns it with the requester ID over a valid/ready interface.
- A watchdog guards against a hung engine.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_BW, 2, width of the requester ID; must satisfy 2^ID_BW >= NUM_REQ.
- TIMEOUT_CYC, 512, cycles allowed from o_eng_start to i_eng_done.
- TMR_BW, 10, watchdog counter width; must satisfy 2^TMR_BW > TIMEOUT_CYC.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  NUM_REQ  per-requester twist valid.
- o_req_ready  out  NUM_REQ  one-hot accept (grant).
- i_req_X  in  [NUM_REQ][6] x MATRIX_BW  per-requester twist words.
- o_eng_start  out  1  one-cycle start pulse to the engine.
- o_eng_X  out  [6] x MATRIX_BW  latched twist driven to the engine.
- i_eng_done  in  1  engine done pulse.
- i_eng_pose  in  [12] x POSE_BW  engine pose; valid only in the i_eng_done cycle.
- o_pose_valid  out  1  result valid.
- i_pose_ready  in  1  result accept.
- o_pose  out  [12] x POSE_BW  captured pose, row-major 3x4 Rt.
- o_pose_id  out  ID_BW  requester that owns the result.
- o_timeout  out  1  qualifies the current result beat as a watchdog abort.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: state = IDLE. Every output is 0: o_eng_X, o_pose and o_pose_id cleared; o_req_ready, o_eng_start, o_pose_valid, o_timeout and o_busy low. Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation aborts the job with no result. The engine is reset through its own reset.
- States: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
- IDLE:
  - Grant is combinational: the first asserted i_req_valid searching from pointer+1 upward, with wrap.
  - o_req_ready = one-hot grant.
  - On valid & ready: latch i_req_X into o_eng_X and the ID into o_pose_id, set pointer = grant, go to ISSUE.
  - No grant is issued in any state other than IDLE, so a single job is in flight.
- ISSUE: o_eng_start = 1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If i_eng_done: copy i_eng_pose into o_pose, set o_timeout = 0, go to HOLD.
  - Else, when the counter reaches TIMEOUT_CYC-1: set o_pose to all 0, set o_timeout = 1, go to HOLD.
  - If done and the timeout coincide, done wins.
- HOLD:
  - o_pose_valid = 1. o_pose, o_pose_id and o_timeout are stable until i_pose_ready.
  - On valid & ready: go to IDLE.
  - Result capture depends on i_eng_done only. i_eng_done arriving in IDLE, ISSUE or HOLD is ignored (stale or late done after a timeout).
- o_eng_X is held stable from ISSUE through WAIT.
- Latency:
  - Accept at cycle T.
  - o_eng_start at T+1.
  - o_pose_valid in the cycle after i_eng_done, i.e. T+1+engine latency+1.
  - Next grant no earlier than the cycle after the result handshake.
- Widths: pure pass-through with no arithmetic on twist or pose; the only arithmetic is the watchdog counter.
- Fairness: a requester holding valid is granted within NUM_REQ jobs.

Decomposition:
- MATRIX_BW and POSE_BW come from RgbdVoConfigPk.
- Add to RgbdVoConfigPk:
  - The state typedef (IDLE/ISSUE/WAIT/HOLD).
  - A localparam for the default TIMEOUT_CYC.
- Sub-module rr_arbiter: combinational round-robin grant from a request vector plus a registered pointer, updated on accept. Parameter N.

Test Plan:
- Single request: req0 presents X = {0x100, 0, 0, 5, 6, 7}; engine model returns pose words 1..12 after 300 cycles.
  - Required: start 1 cycle after accept; o_pose = 1..12, id = 0, o_timeout = 0; valid held until ready.
- Contention: req0 and req1 both valid continuously for 4 jobs.
  - Required: grant order 0, 1, 0, 1; each result's id matches its grant.
- Backpressure: i_pose_ready held low for 50 cycles with req1 pending.
  - Required: o_pose stable, no new grant and no o_eng_start until accept.
- Timeout: engine model never asserts done.
  - Required: valid with o_timeout = 1 and pose all zero exactly TIMEOUT_CYC cycles after start. A later spurious i_eng_done is ignored.
- Coincident done and timeout in the same cycle.
  - Required: engine pose captured, o_timeout = 0.
- Reset asserted mid-WAIT.
  - Required: all outputs 0, state IDLE, requester 0 granted first after release.

Source files
------------

// File: rtl/rodrigues_sched_pkg.sv
// Shared configuration for the RGB-D visual-odometry pipeline: datapath widths,
// Rodrigues scheduler state encoding and watchdog default.
package RgbdVoConfigPk;
  localparam int MATRIX_BW           = 24;
  localparam int POSE_BW             = 32;
  localparam int DEFAULT_TIMEOUT_CYC = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } rod_state_e;
endpackage

// File: rtl/rodrigues_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from pointer+1 with wrap,
// pointer moves to the winner on accept.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_id
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] hi_id, lo_id;
  logic          hi_found, lo_found;

  // lowest request above the pointer wins; otherwise wrap to the lowest request overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        lo_found = 1'b1;
        lo_id    = IW'(i);
        if (IW'(i) > ptr_q) begin
          hi_found = 1'b1;
          hi_id    = IW'(i);
        end
      end
    end
    o_grant_id = hi_found ? hi_id : lo_id;
    o_grant    = lo_found ? (N'(1) << o_grant_id) : '0;
    ptr_d      = i_accept ? o_grant_id : ptr_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= IW'(N - 1);
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rodrigues_sched.sv
// Shares one Rodrigues twist-to-pose engine between NUM_REQ requesters with a
// round-robin grant, one job in flight, and a watchdog on the engine done.
//
// state | meaning
// IDLE  | granting; accept a twist from the round-robin winner
// ISSUE | start pulse to engine, watchdog cleared
// WAIT  | waiting for engine done or watchdog expiry
// HOLD  | result presented until accepted
module rodrigues_sched
  import RgbdVoConfigPk::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ID_BW       = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int TMR_BW      = 10
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ-1:0][5:0][MATRIX_BW-1:0] i_req_X,
  output logic                                   o_eng_start,
  output logic [5:0][MATRIX_BW-1:0]              o_eng_X,
  input  logic                                   i_eng_done,
  input  logic [11:0][POSE_BW-1:0]               i_eng_pose,
  output logic                                   o_pose_valid,
  input  logic                                   i_pose_ready,
  output logic [11:0][POSE_BW-1:0]               o_pose,
  output logic [ID_BW-1:0]                       o_pose_id,
  output logic                                   o_timeout,
  output logic                                   o_busy
);
  localparam int AW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rod_state_e                  state_q;
  logic [5:0][MATRIX_BW-1:0]   eng_x_q;
  logic [11:0][POSE_BW-1:0]    pose_q;
  logic [ID_BW-1:0]            id_q;
  logic                        start_q, valid_q, timeout_q, busy_q;
  logic [TMR_BW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]          gnt;
  logic [AW-1:0]               gnt_id;
  logic                        accept;

  // grant only exists in IDLE, and is forced low while reset is held
  assign o_req_ready = (state_q == IDLE && !i_rst) ? gnt : '0;
  assign accept      = |(i_req_valid & o_req_ready);
  assign cnt_d       = cnt_q + TMR_BW'(1);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req_valid),
    .i_accept   (accept),
    .o_grant    (gnt),
    .o_grant_id (gnt_id)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      eng_x_q   <= '0;
      pose_q    <= '0;
      id_q      <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            eng_x_q   <= i_req_X[gnt_id];
            id_q      <= ID_BW'(gnt_id);
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // done takes priority over a watchdog expiry in the same cycle
          if (i_eng_done) begin
            pose_q    <= i_eng_pose;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= HOLD;
          end else if (cnt_d == TMR_BW'(TIMEOUT_CYC - 1)) begin
            pose_q    <= '0;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (i_pose_ready) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_eng_start  = start_q;
  assign o_eng_X      = eng_x_q;
  assign o_pose_valid = valid_q;
  assign o_pose       = pose_q;
  assign o_pose_id    = id_q;
  assign o_timeout    = timeout_q;
  assign o_busy       = busy_q;
endmodule

// File: tb/tb_rodrigues_sched.sv
// Self-checking bench for rodrigues_sched: directed scenarios plus randomized jobs
// checked against a round-robin / engine-timing reference model.
module tb_rodrigues_sched;
  import RgbdVoConfigPk::*;

  localparam int NR  = 2;
  localparam int IDW = 2;
  localparam int TO  = DEFAULT_TIMEOUT_CYC;
  localparam int TBW = 10;
  localparam int MB  = MATRIX_BW;
  localparam int PB  = POSE_BW;

  typedef logic [5:0][MB-1:0]  twist_t;
  typedef logic [11:0][PB-1:0] pose_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [NR-1:0][5:0][MB-1:0] req_x;
  logic                eng_start;
  twist_t              eng_x;
  logic                eng_done;
  pose_t               eng_pose;
  logic                pose_valid;
  logic                pose_ready;
  pose_t               pose;
  logic [IDW-1:0]      pose_id;
  logic                timeout;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rodrigues_sched #(
    .NUM_REQ(NR), .ID_BW(IDW), .TIMEOUT_CYC(TO), .TMR_BW(TBW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_X      (req_x),
    .o_eng_start  (eng_start),
    .o_eng_X      (eng_x),
    .i_eng_done   (eng_done),
    .i_eng_pose   (eng_pose),
    .o_pose_valid (pose_valid),
    .i_pose_ready (pose_ready),
    .o_pose       (pose),
    .o_pose_id    (pose_id),
    .o_timeout    (timeout),
    .o_busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(int last, logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic pose_t rand_pose();
    pose_t p;
    for (int i = 0; i < 12; i++) p[i] = PB'($urandom);
    return p;
  endfunction

  function automatic twist_t rand_twist();
    twist_t t;
    for (int i = 0; i < 6; i++) t[i] = MB'($urandom);
    return t;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    eng_done   = 1'b0;
    eng_pose   = '0;
    pose_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_x[0]  = rand_twist();
    req_x[1]  = rand_twist();
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if ({eng_start, pose_valid, timeout, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {eng_start, pose_valid, timeout, busy}); end
    checks++; if (eng_x !== '0 || pose !== '0 || pose_id !== '0) begin failures++; $display("FAIL reset_data got eng_x=%h pose_id=%0d exp zero", eng_x, pose_id); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    twist_t tw;
    pose_t  exp_p;
    logic   stable;
    tw = '0;
    tw[0] = MB'(32'h100); tw[3] = MB'(5); tw[4] = MB'(6); tw[5] = MB'(7);
    for (int i = 0; i < 12; i++) exp_p[i] = PB'(i + 1);
    req_x[0]  = tw;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (eng_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_start got start=%b busy=%b exp 1 1", eng_start, busy); end
    checks++; if (eng_x !== tw) begin failures++; $display("FAIL single_eng_x got=%h exp=%h", eng_x, tw); end
    tick();
    checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL single_start_width got=%b exp=0", eng_start); end
    repeat (299) tick();
    checks++; if (pose_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", pose_valid); end
    eng_done = 1'b1;
    eng_pose = exp_p;
    tick();
    eng_done = 1'b0;
    eng_pose = rand_pose();
    checks++; if (pose_valid !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL single_valid got valid=%b timeout=%b exp 1 0", pose_valid, timeout); end
    checks++; if (pose !== exp_p) begin failures++; $display("FAIL single_pose got=%h exp=%h", pose, exp_p); end
    checks++; if (pose_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", pose_id); end
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (pose_valid !== 1'b1 || pose !== exp_p) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL single_hold got stable=%b exp=1", stable); end
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
    checks++; if (pose_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_release got valid=%b busy=%b exp 0 0", pose_valid, busy); end
  endtask

  task automatic test_contention();
    int     order [4];
    pose_t  p;
    int     lat;
    order = '{0, 1, 0, 1};
    do_reset();
    req_x[0]  = rand_twist();
    req_x[1]  = rand_twist();
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (req_ready !== (NR'(1) << order[j])) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%0d", j, req_ready, order[j]); end
      tick();
      checks++; if (eng_start !== 1'b1 || eng_x !== req_x[order[j]]) begin failures++; $display("FAIL contention_issue%0d got start=%b eng_x=%h exp=%h", j, eng_start, eng_x, req_x[order[j]]); end
      lat = $urandom_range(1, 20);
      repeat (lat) tick();
      p = rand_pose();
      eng_done = 1'b1;
      eng_pose = p;
      tick();
      eng_done = 1'b0;
      checks++; if (pose_valid !== 1'b1 || pose_id !== IDW'(order[j]) || pose !== p) begin failures++; $display("FAIL contention_result%0d got valid=%b id=%0d exp id=%0d", j, pose_valid, pose_id, order[j]); end
      pose_ready = 1'b1;
      tick();
      pose_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    pose_t p, held;
    logic  ok_pose, ok_ready, ok_start, ok_valid;
    req_x[0]  = rand_twist();
    req_x[1]  = rand_twist();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    repeat (10) tick();
    p = rand_pose();
    eng_done = 1'b1;
    eng_pose = p;
    tick();
    eng_done = 1'b0;
    held = pose;
    checks++; if (held !== p || pose_id !== 2'd0) begin failures++; $display("FAIL bp_capture got id=%0d pose=%h exp id=0 pose=%h", pose_id, held, p); end
    ok_pose = 1'b1; ok_ready = 1'b1; ok_start = 1'b1; ok_valid = 1'b1;
    repeat (50) begin
      tick();
      if (pose !== p)          ok_pose  = 1'b0;
      if (req_ready !== '0)    ok_ready = 1'b0;
      if (eng_start !== 1'b0)  ok_start = 1'b0;
      if (pose_valid !== 1'b1) ok_valid = 1'b0;
    end
    checks++; if (ok_pose  !== 1'b1) begin failures++; $display("FAIL bp_pose_stable got=%b exp=1", ok_pose); end
    checks++; if (ok_ready !== 1'b1) begin failures++; $display("FAIL bp_no_grant got=%b exp=1", ok_ready); end
    checks++; if (ok_start !== 1'b1) begin failures++; $display("FAIL bp_no_start got=%b exp=1", ok_start); end
    checks++; if (ok_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%b exp=1", ok_valid); end
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (eng_start !== 1'b1 || eng_x !== req_x[1]) begin failures++; $display("FAIL bp_next_start got start=%b eng_x=%h exp=%h", eng_start, eng_x, req_x[1]); end
    repeat (3) tick();
    eng_done = 1'b1;
    eng_pose = rand_pose();
    tick();
    eng_done = 1'b0;
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
  endtask

  task automatic test_timeout();
    req_x[0]  = rand_twist();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    checks++; if (eng_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", eng_start); end
    repeat (TO - 1) tick();
    checks++; if (pose_valid !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", pose_valid); end
    tick();
    checks++; if (pose_valid !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL to_flag got valid=%b timeout=%b exp 1 1", pose_valid, timeout); end
    checks++; if (pose !== '0 || pose_id !== 2'd0) begin failures++; $display("FAIL to_pose got id=%0d pose=%h exp zero", pose_id, pose); end
    eng_done = 1'b1;
    eng_pose = rand_pose();
    tick();
    eng_done = 1'b0;
    checks++; if (pose !== '0 || timeout !== 1'b1) begin failures++; $display("FAIL to_spurious_hold got timeout=%b pose=%h exp 1 zero", timeout, pose); end
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
    checks++; if (pose_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL to_release got valid=%b timeout=%b exp 0 0", pose_valid, timeout); end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    checks++; if (pose_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_spurious_idle got valid=%b busy=%b exp 0 0", pose_valid, busy); end
  endtask

  task automatic test_coincident();
    pose_t p;
    req_x[1]  = rand_twist();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    repeat (TO - 1) tick();
    p = rand_pose();
    eng_done = 1'b1;
    eng_pose = p;
    tick();
    eng_done = 1'b0;
    checks++; if (pose_valid !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL coinc_flag got valid=%b timeout=%b exp 1 0", pose_valid, timeout); end
    checks++; if (pose !== p || pose_id !== 2'd1) begin failures++; $display("FAIL coinc_pose got id=%0d pose=%h exp id=1 pose=%h", pose_id, pose, p); end
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    req_x[0]  = rand_twist();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    repeat (100) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmw_busy got=%b exp=1", busy); end
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, eng_start, pose_valid, timeout, busy} !== '0) begin failures++; $display("FAIL rmw_flags got ready=%b start=%b valid=%b to=%b busy=%b exp 0", req_ready, eng_start, pose_valid, timeout, busy); end
    checks++; if (eng_x !== '0 || pose !== '0 || pose_id !== '0) begin failures++; $display("FAIL rmw_data got eng_x=%h pose_id=%0d exp zero", eng_x, pose_id); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmw_first_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (eng_start !== 1'b1 || eng_x !== req_x[0]) begin failures++; $display("FAIL rmw_restart got start=%b eng_x=%h exp=%h", eng_start, eng_x, req_x[0]); end
    repeat (5) tick();
    eng_done = 1'b1;
    eng_pose = rand_pose();
    tick();
    eng_done = 1'b0;
    pose_ready = 1'b1;
    tick();
    pose_ready = 1'b0;
  endtask

  task automatic test_random();
    int            last, exp_id, lat, dly;
    logic [NR-1:0] v;
    twist_t        tw;
    pose_t         p;
    logic          ok;
    do_reset();
    last = NR - 1;
    for (int j = 0; j < 20; j++) begin
      v = NR'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) req_x[r] = rand_twist();
      req_valid = v;
      exp_id = rr_pick(last, v);
      #1;
      checks++; if (req_ready !== (NR'(1) << exp_id)) begin failures++; $display("FAIL rand_grant%0d got=%b exp=%0d valid=%b", j, req_ready, exp_id, v); end
      tw = req_x[exp_id];
      tick();
      last = exp_id;
      req_valid = '0;
      for (int r = 0; r < NR; r++) req_x[r] = rand_twist();
      checks++; if (eng_start !== 1'b1 || eng_x !== tw) begin failures++; $display("FAIL rand_issue%0d got start=%b eng_x=%h exp=%h", j, eng_start, eng_x, tw); end
      lat = $urandom_range(1, 30);
      repeat (lat) tick();
      checks++; if (eng_x !== tw || pose_valid !== 1'b0) begin failures++; $display("FAIL rand_wait%0d got eng_x=%h valid=%b exp=%h 0", j, eng_x, pose_valid, tw); end
      p = rand_pose();
      eng_done = 1'b1;
      eng_pose = p;
      tick();
      eng_done = 1'b0;
      eng_pose = rand_pose();
      dly = $urandom_range(0, 4);
      ok = 1'b1;
      for (int d = 0; d <= dly; d++) begin
        if (pose_valid !== 1'b1 || pose !== p || pose_id !== IDW'(exp_id) || timeout !== 1'b0) ok = 1'b0;
        if (d < dly) tick();
      end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand_result%0d got id=%0d pose=%h exp id=%0d pose=%h", j, pose_id, pose, exp_id, p); end
      pose_ready = 1'b1;
      tick();
      pose_ready = 1'b0;
      checks++; if (busy !== 1'b0 || pose_valid !== 1'b0) begin failures++; $display("FAIL rand_release%0d got busy=%b valid=%b exp 0 0", j, busy, pose_valid); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_coincident();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
